bg_ram_arbiter: RTL and testbench
=================================

// Module: bg_ram_arbiter
// PURPOSE
//  Shares the single-port background tile RAM (20x15 tiles, 12-bit colour) between two requesters.
//  Requester 0 is game logic (reads, plus writes when food is eaten); requester 1 is the renderer (reads only).
//  The block sits between those requesters and the background RAM, and is the only driver of the RAM address, data and wren.
//  It computes the tile address y*BG_W+x, applies round-robin arbitration, and returns read data tagged to the issuing requester.
// PARAMETERS
//  BG_W        20   tiles per row; also the address stride
//  BG_H        15   tile rows
//  ADDR_W      15   width of the RAM address port
//  COLOR_W     12   tile colour width
//  RD_LATENCY  1    cycles from ram_addr registered to ram_q valid (legal range 1..3)
// PORTS
//  clock        in   1        system clock, all logic rising-edge
//  reset        in   1        asynchronous, active-high; clears all state
//  l_req        in   1        logic requester: access request, held until l_gnt
//  l_we         in   1        1=write, 0=read; stable while l_req
//  l_x          in   5        tile column
//  l_y          in   4        tile row
//  l_wdata      in   COLOR_W  write colour
//  l_gnt        out  1        1-cycle pulse: request accepted
//  l_rvalid     out  1        1-cycle pulse: l_rdata holds the read result
//  l_rdata      out  COLOR_W  read colour
//  r_req        in   1        renderer request (read only), held until r_gnt
//  r_x          in   5        tile column
//  r_y          in   4        tile row
//  r_gnt        out  1        1-cycle pulse: request accepted
//  r_rvalid     out  1        1-cycle pulse: r_rdata valid
//  r_rdata      out  COLOR_W  read colour
//  oob_err      out  1        1-cycle pulse: the granted request had x>=BG_W or y>=BG_H
//  ram_addr     out  ADDR_W   to RAM address port (registered)
//  ram_data     out  COLOR_W  to RAM data port (registered)
//  ram_wren     out  1        to RAM wren (registered)
//  ram_q        in   COLOR_W  RAM read data
// BEHAVIOUR
//  - Reset values: all outputs 0; the round-robin pointer favours the logic requester; the in-flight pipeline is emptied.
//  - Arbitration, cycle t:
//    - If exactly one requester asserts req, that requester wins.
//    - If both assert req, the requester the pointer favours wins, and the pointer flips to the other requester.
//  - Cycle t+1, all driven from registers:
//    - The winner's gnt pulses.
//    - ram_addr = y*BG_W+x, zero-extended to ADDR_W.
//    - ram_wren = we, for the logic requester only.
//  - Throughput: one access per cycle.
//    - A requester whose gnt is high at t+1 must drop req or present a new request at t+1.
//    - A req still high in the gnt cycle is treated as a new request.
//  - Reads: ram_q is sampled at t+1+RD_LATENCY; rvalid and rdata appear on the issuing port at t+2+RD_LATENCY.
//    - The valid/rdata pair is registered.
//    - Grant-to-rvalid latency is RD_LATENCY+1.
//    - A tag shift register, RD_LATENCY+1 deep, holds {valid, requester id, oob} per issued access.
//  - Writes: no rvalid is produced; ram_wren is high for exactly 1 cycle.
//  - Ordering: accesses complete in grant order.
//    - A read granted after a write to the same tile returns the written value.
//    - A read-during-write hazard cannot occur, because there is one op per cycle.
//  - Out-of-range coordinates (x>=BG_W or y>=BG_H):
//    - The request is still granted and oob_err pulses with gnt.
//    - ram_wren stays 0 and ram_addr holds its previous value.
//    - A read completes at the normal latency with rdata=0.
//  - rdata holds its last value when rvalid=0. The idle port's rdata is unchanged.
//  - Reset mid-operation discards in-flight reads: no rvalid is produced for an access granted before reset.
// STRUCTURE
//  - Shared package (bg_pkg): BG_W, BG_H, COLOR_W, ADDR_W, the requester ID enum {REQ_LOGIC=0, REQ_RENDER=1}, and the tag struct {vld, id, oob}.
//  - One sub-module, bg_rd_tag_pipe: a parameterised delay line, RD_LATENCY+1 deep, that carries the tag alongside the RAM read.
//  - Everything else is flat: arbiter, address multiply-add register, and output steering.
// TESTING
//  1. After reset, pulse r_req at x=3,y=2 (RAM preloaded 0xABC at addr 43).
//     -> r_gnt at +1, ram_addr=43, r_rvalid with r_rdata=0xABC at gnt+2 (RD_LATENCY=1).
//  2. l_req write x=19,y=14,wdata=0xF00, then r_req read of the same tile.
//     -> ram_wren=1 with ram_addr=299 for 1 cycle, then r_rdata=0xF00.
//  3. l_req and r_req both held high for 6 cycles.
//     -> grants alternate L,R,L,R,L,R with no idle cycle; each read result is routed to the correct port.
//  4. l_req write x=20,y=0.
//     -> l_gnt and oob_err pulse together, ram_wren stays 0, RAM contents unchanged.
//  5. Assert reset 1 cycle after r_gnt.
//     -> r_rvalid never pulses; all outputs read 0 after reset; the first grant after reset goes to logic on a tie.
//  6. Repeat tests 1 and 3 with RD_LATENCY=3.
//     -> rvalid arrives 4 cycles after gnt, grant order is preserved, and there are no dropped or duplicated pulses.

Source files
------------

// File: rtl/bg_pkg.sv
// Shared definitions for the background tile RAM arbiter.
//  - Playfield geometry (BG_W x BG_H tiles), RAM address and colour widths.
//  - Requester identifiers and the read tag carried alongside a RAM read.
//  - Helpers for tile range checking and linear tile address computation.
package bg_pkg;

  localparam int BG_W    = 20;
  localparam int BG_H    = 15;
  localparam int ADDR_W  = 15;
  localparam int COLOR_W = 12;
  localparam int X_W     = 5;
  localparam int Y_W     = 4;

  typedef enum logic {
    REQ_LOGIC  = 1'b0,
    REQ_RENDER = 1'b1
  } req_id_e;

  // One entry per issued access; vld is set only for reads.
  typedef struct packed {
    logic    vld;
    req_id_e id;
    logic    oob;
  } rd_tag_t;

  function automatic logic tile_in_range(input logic [X_W-1:0] x,
                                         input logic [Y_W-1:0] y);
    return (x < X_W'(BG_W)) && (y < Y_W'(BG_H));
  endfunction

  // Row-major tile address: y * BG_W + x.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(BG_W) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/bg_rd_tag_pipe.sv
// Delay line carrying the read tag in step with the RAM read pipeline.
//  clock, reset : rising-edge clock, asynchronous active-high reset
//  tag_i        : tag of the access being arbitrated this cycle
//  tag_o        : the same tag DEPTH cycles later, aligned with ram_q
// Reset empties every stage so no in-flight read survives a reset.
module bg_rd_tag_pipe
  import bg_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clock,
  input  logic    reset,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bg_ram_arbiter.sv
// Round-robin arbiter sharing the single-port background tile RAM between
// the game logic (read/write) and the renderer (read only).
//  clock, reset        : rising-edge clock, asynchronous active-high reset
//  l_req/l_we/l_x/l_y/l_wdata -> l_gnt, l_rvalid, l_rdata : logic requester
//  r_req/r_x/r_y       -> r_gnt, r_rvalid, r_rdata         : renderer
//  oob_err             : pulses with gnt when the granted tile is off-field
//  ram_addr/ram_data/ram_wren (registered), ram_q          : RAM port
//
// Handshake: a requester holds req (and its operands) until its gnt pulse.
// Arbitration happens in the cycle req is seen; gnt pulses the next cycle.
// Any req still high during the gnt cycle is a fresh request, so a
// continuously held req is served every cycle it wins. A read returns one
// rvalid pulse RD_LATENCY+1 cycles after its gnt; writes return nothing.
module bg_ram_arbiter
  import bg_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               l_req,
  input  logic               l_we,
  input  logic [4:0]         l_x,
  input  logic [3:0]         l_y,
  input  logic [COLOR_W-1:0] l_wdata,
  output logic               l_gnt,
  output logic               l_rvalid,
  output logic [COLOR_W-1:0] l_rdata,
  input  logic               r_req,
  input  logic [4:0]         r_x,
  input  logic [3:0]         r_y,
  output logic               r_gnt,
  output logic               r_rvalid,
  output logic [COLOR_W-1:0] r_rdata,
  output logic               oob_err,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [COLOR_W-1:0] ram_data,
  output logic               ram_wren,
  input  logic [COLOR_W-1:0] ram_q
);

  req_id_e             ptr_q, ptr_d;
  logic                l_win, r_win, any_win;
  logic [4:0]          sel_x;
  logic [3:0]          sel_y;
  logic                sel_oob;
  logic                wren_d;
  logic [ADDR_W-1:0]   addr_d;
  rd_tag_t             tag_d, tag_out;
  logic [COLOR_W-1:0]  rd_colour;

  logic                l_gnt_q, r_gnt_q, oob_q, ram_wren_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [COLOR_W-1:0]  ram_data_q;
  logic                l_rvalid_q, r_rvalid_q;
  logic [COLOR_W-1:0]  l_rdata_q, r_rdata_q;

  // The pointer only moves on a tie; a lone requester never disturbs it.
  always_comb begin
    l_win = 1'b0;
    r_win = 1'b0;
    ptr_d = ptr_q;
    if (l_req && r_req) begin
      if (ptr_q == REQ_LOGIC) begin
        l_win = 1'b1;
        ptr_d = REQ_RENDER;
      end else begin
        r_win = 1'b1;
        ptr_d = REQ_LOGIC;
      end
    end else begin
      l_win = l_req;
      r_win = r_req;
    end
  end

  assign any_win = l_win | r_win;
  assign sel_x   = l_win ? l_x : r_x;
  assign sel_y   = l_win ? l_y : r_y;
  assign sel_oob = any_win && !tile_in_range(sel_x, sel_y);
  assign wren_d  = l_win && l_we && !sel_oob;
  assign addr_d  = tile_addr(sel_x, sel_y);

  // Off-field reads still travel the pipeline so they complete on time,
  // but their result is forced to zero at the output.
  always_comb begin
    tag_d.vld = r_win || (l_win && !l_we);
    tag_d.id  = l_win ? REQ_LOGIC : REQ_RENDER;
    tag_d.oob = sel_oob;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q      <= REQ_LOGIC;
      l_gnt_q    <= 1'b0;
      r_gnt_q    <= 1'b0;
      oob_q      <= 1'b0;
      ram_wren_q <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      l_gnt_q    <= l_win;
      r_gnt_q    <= r_win;
      oob_q      <= sel_oob;
      ram_wren_q <= wren_d;
      // Off-field accesses leave the address bus where it was.
      if (any_win && !sel_oob) ram_addr_q <= addr_d;
      if (wren_d)              ram_data_q <= l_wdata;
    end
  end

  // Tag enters in the arbitration cycle and emerges when ram_q is valid.
  bg_rd_tag_pipe #(
    .DEPTH(RD_LATENCY + 1)
  ) u_tag_pipe (
    .clock (clock),
    .reset (reset),
    .tag_i (tag_d),
    .tag_o (tag_out)
  );

  assign rd_colour = tag_out.oob ? '0 : ram_q;

  // Only the issuing port's rdata is updated; the other keeps its value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      l_rvalid_q <= 1'b0;
      r_rvalid_q <= 1'b0;
      l_rdata_q  <= '0;
      r_rdata_q  <= '0;
    end else begin
      l_rvalid_q <= tag_out.vld && (tag_out.id == REQ_LOGIC);
      r_rvalid_q <= tag_out.vld && (tag_out.id == REQ_RENDER);
      if (tag_out.vld && (tag_out.id == REQ_LOGIC))  l_rdata_q <= rd_colour;
      if (tag_out.vld && (tag_out.id == REQ_RENDER)) r_rdata_q <= rd_colour;
    end
  end

  assign l_gnt    = l_gnt_q;
  assign r_gnt    = r_gnt_q;
  assign oob_err  = oob_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;
  assign l_rvalid = l_rvalid_q;
  assign r_rvalid = r_rvalid_q;
  assign l_rdata  = l_rdata_q;
  assign r_rdata  = r_rdata_q;

endmodule

// File: tb/tb_bg_ram_arbiter.sv
// Bench for bg_ram_arbiter: two instances (read latency 1 and 3) share the
// same stimulus, each with its own RAM. A tile-level reference model predicts
// grants, RAM port activity and tagged read results.
module tb_bg_ram_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // shared stimulus
  logic        l_req = 1'b0, l_we = 1'b0, r_req = 1'b0;
  logic [4:0]  l_x = '0, r_x = '0;
  logic [3:0]  l_y = '0, r_y = '0;
  logic [11:0] l_wdata = '0;

  // instance A (latency 1) and B (latency 3) outputs
  logic        l_gnt_a, r_gnt_a, l_rvalid_a, r_rvalid_a, oob_a, wren_a;
  logic [11:0] l_rdata_a, r_rdata_a, data_a, q_a;
  logic [14:0] addr_a;
  logic        l_gnt_b, r_gnt_b, l_rvalid_b, r_rvalid_b, oob_b, wren_b;
  logic [11:0] l_rdata_b, r_rdata_b, data_b, q_b;
  logic [14:0] addr_b;

  bg_ram_arbiter #(.RD_LATENCY(LAT_A)) u_dut_a (
    .clock(clock), .reset(reset),
    .l_req(l_req), .l_we(l_we), .l_x(l_x), .l_y(l_y), .l_wdata(l_wdata),
    .l_gnt(l_gnt_a), .l_rvalid(l_rvalid_a), .l_rdata(l_rdata_a),
    .r_req(r_req), .r_x(r_x), .r_y(r_y),
    .r_gnt(r_gnt_a), .r_rvalid(r_rvalid_a), .r_rdata(r_rdata_a),
    .oob_err(oob_a), .ram_addr(addr_a), .ram_data(data_a), .ram_wren(wren_a),
    .ram_q(q_a)
  );

  bg_ram_arbiter #(.RD_LATENCY(LAT_B)) u_dut_b (
    .clock(clock), .reset(reset),
    .l_req(l_req), .l_we(l_we), .l_x(l_x), .l_y(l_y), .l_wdata(l_wdata),
    .l_gnt(l_gnt_b), .l_rvalid(l_rvalid_b), .l_rdata(l_rdata_b),
    .r_req(r_req), .r_x(r_x), .r_y(r_y),
    .r_gnt(r_gnt_b), .r_rvalid(r_rvalid_b), .r_rdata(r_rdata_b),
    .oob_err(oob_b), .ram_addr(addr_b), .ram_data(data_b), .ram_wren(wren_b),
    .ram_q(q_b)
  );

  // RAM models with a preload port
  logic        load_en = 1'b0;
  logic [14:0] load_addr = '0;
  logic [11:0] load_data = '0;
  logic [11:0] mem_a [0:32767];
  logic [11:0] mem_b [0:32767];
  logic [11:0] qb1, qb2, qb3;

  always @(posedge clock) begin
    if (load_en)     mem_a[load_addr] <= load_data;
    else if (wren_a) mem_a[addr_a] <= data_a;
    q_a <= mem_a[addr_a];
  end

  always @(posedge clock) begin
    if (load_en)     mem_b[load_addr] <= load_data;
    else if (wren_b) mem_b[addr_b] <= data_b;
    qb1 <= mem_b[addr_b];
    qb2 <= qb1;
    qb3 <= qb2;
  end
  assign q_b = qb3;

  // reference model state and scoreboard
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        ptr = 1'b0;          // 0: logic favoured on a tie
  logic        e_lgnt = 1'b0, e_rgnt = 1'b0, e_oob = 1'b0, e_wren = 1'b0;
  logic [14:0] e_addr = '0;
  logic [11:0] e_data = '0;
  logic [11:0] shadow [0:14][0:19];
  // index: 0 = A logic, 1 = A render, 2 = B logic, 3 = B render
  logic [11:0] exp_q [4][$];
  int          due_q [4][$];
  logic [11:0] last_rd [4];

  task automatic model_clear();
    ptr = 1'b0;
    e_lgnt = 1'b0; e_rgnt = 1'b0; e_oob = 1'b0; e_wren = 1'b0;
    e_addr = '0; e_data = '0;
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      due_q[k].delete();
      last_rd[k] = '0;
    end
  endtask

  // Predict the effect of the coming clock edge from the current requests.
  task automatic model_edge();
    logic        lw, rw, oob;
    int          x, y, g, k;
    logic [11:0] v;
    lw = 1'b0; rw = 1'b0;
    if (l_req && r_req) begin
      lw = ~ptr; rw = ptr; ptr = ~ptr;
    end else begin
      lw = l_req; rw = r_req;
    end
    e_lgnt = lw; e_rgnt = rw; e_oob = 1'b0; e_wren = 1'b0;
    if (lw || rw) begin
      x = lw ? int'(l_x) : int'(r_x);
      y = lw ? int'(l_y) : int'(r_y);
      oob = (x >= 20) || (y >= 15);
      e_oob = oob;
      g = cyc + 1;
      if (!oob) e_addr = 15'(y * 20 + x);
      if (lw && l_we) begin
        if (!oob) begin
          e_wren = 1'b1;
          e_data = l_wdata;
          shadow[y][x] = l_wdata;
        end
      end else begin
        v = oob ? 12'h000 : shadow[y][x];
        k = lw ? 0 : 1;
        exp_q[k].push_back(v);   due_q[k].push_back(g + LAT_A + 1);
        exp_q[k+2].push_back(v); due_q[k+2].push_back(g + LAT_B + 1);
      end
    end
  endtask

  task automatic monitor_one(input int d, input logic lg, input logic rg,
                             input logic oe, input logic we,
                             input logic [14:0] addr, input logic [11:0] data,
                             input logic lrv, input logic [11:0] lrd,
                             input logic rrv, input logic [11:0] rrd);
    logic        rv;
    logic [11:0] rd, ev;
    int          k, dd;
    n_tests++;
    if ({lg, rg, oe, we} !== {e_lgnt, e_rgnt, e_oob, e_wren}) begin
      n_fail++;
      $display("FAIL ctrl dut%0d cyc%0d: gnt_l/gnt_r/oob/wren got %b expected %b",
               d, cyc, {lg, rg, oe, we}, {e_lgnt, e_rgnt, e_oob, e_wren});
    end
    n_tests++;
    if (addr !== e_addr) begin
      n_fail++;
      $display("FAIL ram_addr dut%0d cyc%0d: got %0d expected %0d", d, cyc, addr, e_addr);
    end
    if (e_wren) begin
      n_tests++;
      if (data !== e_data) begin
        n_fail++;
        $display("FAIL ram_data dut%0d cyc%0d: got %h expected %h", d, cyc, data, e_data);
      end
    end
    for (int p = 0; p < 2; p++) begin
      k  = d * 2 + p;
      rv = p ? rrv : lrv;
      rd = p ? rrd : lrd;
      if (rv) begin
        n_tests++;
        if (exp_q[k].size() == 0) begin
          n_fail++;
          $display("FAIL rvalid dut%0d port%0d cyc%0d: got unexpected pulse expected none", d, p, cyc);
        end else begin
          dd = due_q[k].pop_front();
          ev = exp_q[k].pop_front();
          last_rd[k] = ev;
          if (dd != cyc || rd !== ev) begin
            n_fail++;
            $display("FAIL rdata dut%0d port%0d: got %h at cyc%0d expected %h at cyc%0d",
                     d, p, rd, cyc, ev, dd);
          end
        end
      end else begin
        n_tests++;
        if (rd !== last_rd[k]) begin
          n_fail++;
          $display("FAIL rdata_hold dut%0d port%0d cyc%0d: got %h expected %h", d, p, cyc, rd, last_rd[k]);
        end
        if (due_q[k].size() > 0) begin
          n_tests++;
          if (due_q[k][0] <= cyc) begin
            n_fail++;
            $display("FAIL rvalid_missing dut%0d port%0d: got none at cyc%0d expected pulse at cyc%0d",
                     d, p, cyc, due_q[k][0]);
            void'(due_q[k].pop_front());
            void'(exp_q[k].pop_front());
          end
        end
      end
    end
  endtask

  // One clock: model the edge, advance, then check at the falling edge.
  task automatic tick();
    if (reset) model_clear(); else model_edge();
    @(posedge clock);
    cyc++;
    @(negedge clock);
    monitor_one(0, l_gnt_a, r_gnt_a, oob_a, wren_a, addr_a, data_a,
                l_rvalid_a, l_rdata_a, r_rvalid_a, r_rdata_a);
    monitor_one(1, l_gnt_b, r_gnt_b, oob_b, wren_b, addr_b, data_b,
                l_rvalid_b, l_rdata_b, r_rvalid_b, r_rdata_b);
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if ({l_gnt_a, r_gnt_a, l_rvalid_a, r_rvalid_a, oob_a, wren_a, addr_a, data_a,
         l_rdata_a, r_rdata_a} !== '0) begin
      n_fail++;
      $display("FAIL %s dut0: got nonzero outputs addr=%0d wren=%b expected all 0", name, addr_a, wren_a);
    end
    n_tests++;
    if ({l_gnt_b, r_gnt_b, l_rvalid_b, r_rvalid_b, oob_b, wren_b, addr_b, data_b,
         l_rdata_b, r_rdata_b} !== '0) begin
      n_fail++;
      $display("FAIL %s dut1: got nonzero outputs addr=%0d wren=%b expected all 0", name, addr_b, wren_b);
    end
  endtask

  task automatic drain();
    l_req = 1'b0; r_req = 1'b0; l_we = 1'b0;
    repeat (8) tick();
    n_tests++;
    if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d reads outstanding expected 0",
               exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
    end
  endtask

  task automatic test_reset();
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 20; x++) shadow[y][x] = 12'($urandom);
    shadow[2][3] = 12'hABC;
    #1 reset = 1'b1;
    model_clear();
    for (int i = 0; i < 300; i++) begin
      load_en = 1'b1;
      load_addr = 15'(i);
      load_data = shadow[i / 20][i % 20];
      tick();
    end
    load_en = 1'b0;
    tick();
    check_all_zero("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    r_req = 1'b1; r_x = 5'd3; r_y = 4'd2;
    tick();
    r_req = 1'b0;
    n_tests++;
    if (r_gnt_a !== 1'b1 || l_gnt_a !== 1'b0 || addr_a !== 15'd43) begin
      n_fail++;
      $display("FAIL single_gnt: got r_gnt=%b l_gnt=%b addr=%0d expected 1 0 43", r_gnt_a, l_gnt_a, addr_a);
    end
    tick();
    tick();
    n_tests++;
    if (r_rvalid_a !== 1'b1 || r_rdata_a !== 12'hABC || r_rvalid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL single_lat1: got rvalid=%b rdata=%h rvalid_b=%b expected 1 abc 0",
               r_rvalid_a, r_rdata_a, r_rvalid_b);
    end
    tick();
    tick();
    n_tests++;
    if (r_rvalid_b !== 1'b1 || r_rdata_b !== 12'hABC) begin
      n_fail++;
      $display("FAIL single_lat3: got rvalid=%b rdata=%h expected 1 abc", r_rvalid_b, r_rdata_b);
    end
    drain();
  endtask

  task automatic test_write_then_read();
    l_req = 1'b1; l_we = 1'b1; l_x = 5'd19; l_y = 4'd14; l_wdata = 12'hF00;
    tick();
    n_tests++;
    if (wren_a !== 1'b1 || addr_a !== 15'd299 || data_a !== 12'hF00 || l_gnt_a !== 1'b1) begin
      n_fail++;
      $display("FAIL write_port: got wren=%b addr=%0d data=%h gnt=%b expected 1 299 f00 1",
               wren_a, addr_a, data_a, l_gnt_a);
    end
    l_req = 1'b0; l_we = 1'b0;
    r_req = 1'b1; r_x = 5'd19; r_y = 4'd14;
    tick();
    r_req = 1'b0;
    n_tests++;
    if (wren_a !== 1'b0 || r_gnt_a !== 1'b1) begin
      n_fail++;
      $display("FAIL write_pulse: got wren=%b r_gnt=%b expected 0 1", wren_a, r_gnt_a);
    end
    tick();
    tick();
    n_tests++;
    if (r_rvalid_a !== 1'b1 || r_rdata_a !== 12'hF00) begin
      n_fail++;
      $display("FAIL write_readback: got rvalid=%b rdata=%h expected 1 f00", r_rvalid_a, r_rdata_a);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    l_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      l_req = 1'b1; r_req = 1'b1;
      l_x = 5'($urandom_range(0, 19)); l_y = 4'($urandom_range(0, 14));
      r_x = 5'($urandom_range(0, 19)); r_y = 4'($urandom_range(0, 14));
      tick();
      n_tests++;
      if (l_gnt_a !== (i % 2 == 0) || r_gnt_a !== (i % 2 == 1) ||
          l_gnt_b !== (i % 2 == 0) || r_gnt_b !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL alternate[%0d]: got gnt_l/gnt_r %b%b/%b%b expected %b%b",
                 i, l_gnt_a, r_gnt_a, l_gnt_b, r_gnt_b, (i % 2 == 0), (i % 2 == 1));
      end
    end
    drain();
  endtask

  task automatic test_out_of_range();
    logic [14:0] prev;
    prev = e_addr;
    l_req = 1'b1; l_we = 1'b1; l_x = 5'd20; l_y = 4'd0; l_wdata = 12'h123;
    tick();
    n_tests++;
    if (l_gnt_a !== 1'b1 || oob_a !== 1'b1 || wren_a !== 1'b0 || addr_a !== prev) begin
      n_fail++;
      $display("FAIL oob_write: got gnt=%b oob=%b wren=%b addr=%0d expected 1 1 0 %0d",
               l_gnt_a, oob_a, wren_a, addr_a, prev);
    end
    // tile (0,1) shares the address an unguarded (20,0) write would hit
    l_we = 1'b0; l_x = 5'd0; l_y = 4'd1;
    tick();
    l_x = 5'd3; l_y = 4'd15;
    tick();
    l_req = 1'b0;
    n_tests++;
    if (oob_a !== 1'b1 || l_gnt_a !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_read_gnt: got oob=%b gnt=%b expected 1 1", oob_a, l_gnt_a);
    end
    tick();
    tick();
    n_tests++;
    if (l_rvalid_a !== 1'b1 || l_rdata_a !== 12'h000) begin
      n_fail++;
      $display("FAIL oob_read_data: got rvalid=%b rdata=%h expected 1 000", l_rvalid_a, l_rdata_a);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      l_req = 1'($urandom_range(0, 1));
      r_req = 1'($urandom_range(0, 1));
      l_we  = 1'($urandom_range(0, 1));
      l_x = 5'($urandom_range(0, 21)); l_y = 4'($urandom_range(0, 15));
      r_x = 5'($urandom_range(0, 21)); r_y = 4'($urandom_range(0, 15));
      l_wdata = 12'($urandom);
      tick();
    end
    drain();
  endtask

  task automatic test_reset_midop();
    r_req = 1'b1; r_x = 5'd5; r_y = 4'd5;
    tick();
    r_req = 1'b0;
    n_tests++;
    if (r_gnt_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_gnt: got r_gnt=%b expected 1", r_gnt_a);
    end
    tick();
    #2 reset = 1'b1;
    model_clear();
    #1 check_all_zero("midop_reset");
    repeat (5) tick();
    reset = 1'b0;
    l_req = 1'b1; r_req = 1'b1; l_we = 1'b0;
    l_x = 5'd1; l_y = 4'd1; r_x = 5'd2; r_y = 4'd2;
    tick();
    n_tests++;
    if (l_gnt_a !== 1'b1 || r_gnt_a !== 1'b0 || l_gnt_b !== 1'b1 || r_gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_after_reset: got gnt_l/gnt_r %b%b/%b%b expected 10/10",
               l_gnt_a, r_gnt_a, l_gnt_b, r_gnt_b);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_then_read();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
